// File: rtl/regs_pkg.sv
// Shared widths and requester identifiers for the register-file writeback arbiter.
package regs_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_e;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Writeback requester handshakes and the single register-file write port.
// Handshake: a request transfers on a rising clk edge where valid and ready are both 1;
// a requester holds valid with stable rd/data until it sees ready.
interface regs_wb_arbiter_if #(
  parameter int DATA_W = regs_pkg::DATA_W,
  parameter int ADDR_W = regs_pkg::ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; ready is granted only to a valid requester, so ready==handshake.
module rr_arb2
  import regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] ready
);

  req_idx_e last_grant;

  always_comb begin
    ready = 2'b00;
    if (rst) begin
      unique case (valid)
        2'b01:   ready = 2'b01;
        2'b10:   ready = 2'b10;
        // Tie goes to whichever requester did not win last time.
        2'b11:   ready = (last_grant == REQ_ALU) ? 2'b10 : 2'b01;
        default: ready = 2'b00;
      endcase
    end
  end

  // Reset value makes the ALU win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= REQ_LSU;
    end else if (ready[REQ_LSU]) begin
      last_grant <= REQ_LSU;
    end else if (ready[REQ_ALU]) begin
      last_grant <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port,
// flags read-after-write hazards and counts contention cycles.
module regs_wb_arbiter #(
  parameter int DATA_W = regs_pkg::DATA_W,
  parameter int ADDR_W = regs_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regs_wb_arbiter_if.slave  bus,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              hz_rs1,
  output logic              hz_rs2,
  output logic [15:0]       conflict_cnt
);

  logic [1:0] valid;
  logic [1:0] ready;
  logic       hs_alu;
  logic       hs_lsu;

  // Bit positions follow regs_pkg::req_idx_e (ALU=0, LSU=1).
  assign valid = {bus.lsu_valid, bus.alu_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .ready (ready)
  );

  assign bus.alu_ready = ready[regs_pkg::REQ_ALU];
  assign bus.lsu_ready = ready[regs_pkg::REQ_LSU];
  assign hs_alu        = bus.alu_valid & bus.alu_ready;
  assign hs_lsu        = bus.lsu_valid & bus.lsu_ready;

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (hs_alu) begin
      bus.wr_en   <= (bus.alu_rd != '0);
      bus.wr_addr <= bus.alu_rd;
      bus.wr_data <= bus.alu_data;
    end else if (hs_lsu) begin
      bus.wr_en   <= (bus.lsu_rd != '0);
      bus.wr_addr <= bus.lsu_rd;
      bus.wr_data <= bus.lsu_data;
    end else begin
      bus.wr_en   <= 1'b0;
    end
  end

  function automatic logic hazard(input logic [ADDR_W-1:0] rs);
    logic hit;
    hit = (bus.wr_en && (rs == bus.wr_addr))
       || (bus.alu_valid && (rs == bus.alu_rd))
       || (bus.lsu_valid && (rs == bus.lsu_rd));
    return (rs != '0) && hit;
  endfunction

  assign hz_rs1 = hazard(rs1_addr);
  assign hz_rs2 = hazard(rs2_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= 16'd0;
    end else if (bus.alu_valid && bus.lsu_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports alu_valid input 1, alu_ready output 1, alu_rd input ADDR_W, alu_data input DATA_W: requester 0 (ALU writeback).
REQ-006 SHALL have ports lsu_valid input 1, lsu_ready output 1, lsu_rd input ADDR_W, lsu_data input DATA_W: requester 1 (load writeback).
REQ-007 SHALL have ports wr_en output 1, wr_addr output ADDR_W, wr_data output DATA_W: the single register-file write port, all registered.
REQ-008 SHALL have ports rs1_addr, rs2_addr input ADDR_W and hz_rs1, hz_rs2 output 1: read-after-write hazard flags for the register-file read ports.
REQ-009 SHALL have port conflict_cnt output 16: saturating count of cycles with both requesters valid.

Function
REQ-010 SHALL accept a request on a cycle where valid and ready are both 1 (handshake).
REQ-011 SHALL assert ready to at most one requester per cycle; ready depends only on valids, last_grant and rst, never on wr_en.
REQ-012 SHALL grant the sole valid requester when exactly one is valid.
REQ-013 SHALL, when both are valid, grant the requester not recorded in last_grant (round-robin).
REQ-014 SHALL update last_grant only on a handshake; an idle cycle leaves it unchanged.
REQ-015 SHALL, one cycle after a handshake, present wr_en=1 with the granted rd and data on wr_addr/wr_data (latency 1).
REQ-016 SHALL, for a handshake with rd==0, still consume the request but drive wr_en=0 the following cycle.
REQ-017 SHALL drive wr_en=0 on cycles following no handshake; wr_addr/wr_data hold their last values.
REQ-018 SHALL, when both requesters target the same rd simultaneously, write them in grant order across consecutive cycles; the later write wins.
REQ-019 SHALL drive hz_rsN=1 combinationally when rsN_addr!=0 and rsN_addr equals wr_addr with wr_en=1, or equals the rd of any valid requester; otherwise 0.
REQ-020 SHALL drive hz_rsN=0 whenever rsN_addr==0.
REQ-021 SHALL increment conflict_cnt each cycle alu_valid and lsu_valid are both 1, saturating at 0xFFFF.
REQ-022 SHALL permit a requester to hold valid with stable rd/data until ready; payload changes while not ready are not required to be tolerated.

Reset
REQ-023 SHALL, on a rising clk edge with rst==0, set wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (ALU wins first tie), conflict_cnt=0.
REQ-024 SHALL drive alu_ready=0 and lsu_ready=0 while rst==0; no handshake occurs during reset.
REQ-025 SHALL discard a write pending for the next cycle if rst is asserted mid-operation; wr_en is 0 on the cycle after reset.

Structure
REQ-026 SHALL take DATA_W, ADDR_W and a requester-index enum (REQ_ALU=0, REQ_LSU=1) from shared package regs_pkg.
REQ-027 SHALL place two-way round-robin grant logic plus last_grant register in sub-module rr_arb2; output register, hazard compare and counter stay in regs_wb_arbiter.

Verification
REQ-028 SHALL cover: reset, then alu_valid=1 rd=5 data=0x1234 alone -> alu_ready=1 same cycle; next cycle wr_en=1 wr_addr=5 wr_data=0x1234.
REQ-029 SHALL cover: both valid for 4 cycles (alu rd=1, lsu rd=2, held) -> grants ALU,LSU,ALU,LSU; conflict_cnt=4.
REQ-030 SHALL cover: lsu_valid rd=0 data=0xDEAD -> lsu_ready=1; next cycle wr_en=0; hz_rs1=0 with rs1_addr=0.
REQ-031 SHALL cover: both valid rd=7 (alu 0xA, lsu 0xB) from reset -> wr 7=0xA then 7=0xB on consecutive cycles; hz_rs2=1 for rs2_addr=7 throughout.
REQ-032 SHALL cover: handshake then rst=0 next edge -> wr_en=0, wr_addr=0, readies 0, conflict_cnt=0; after release, first tie grants ALU.
REQ-033 SHALL cover: both valid held 70000 cycles -> conflict_cnt saturates at 0xFFFF, no wrap.
